// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state type and cycle-count helper for serial_alu.
package alu_pkg;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to sweep a full word.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational DIGIT-bit ALU slice. Ripples carry across its
// DIGIT bits for ADD/SUB and reports the carry into its top bit so the
// caller can derive signed overflow. Carries are 0 for bitwise/reserved ops.
module alu_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] y,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT-1:0] b_eff;

  // SUB adds the inverted b; the caller supplies c_in=1 for two's complement.
  assign b_eff = (op == OP_SUB) ? ~b : b;

  // Per-op digit result with a rippled carry for the arithmetic ops.
  always_comb begin
    logic c;
    y     = '0;
    c_out = 1'b0;
    c_msb = 1'b0;
    c     = c_in;
    case (op)
      OP_MOV: y = a;
      OP_NOT: y = ~a;
      OP_OR:  y = a | b;
      OP_AND: y = a & b;
      OP_ADD, OP_SUB: begin
        for (int i = 0; i < DIGIT; i++) begin
          if (i == DIGIT - 1) c_msb = c;
          y[i] = a[i] ^ b_eff[i] ^ c;
          c    = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
        end
        c_out = c;
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// serial_alu: multi-cycle ALU processing WIDTH-bit words DIGIT bits per clock,
// LSB first, through one alu_slice. start/busy/done handshake:
//   start is sampled only while busy=0 (IDLE or DONE); the sampling edge
//   latches a, b, op, c_in. busy is high for the N=WIDTH/DIGIT RUN cycles;
//   done pulses for one cycle after result/c_out load. start during busy is
//   dropped, never queued.
// DIGIT must divide WIDTH with DIGIT < WIDTH.
// Optional build macro SERIAL_ALU_FLAGS_EN adds registered zero/ovf outputs.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
`ifdef SERIAL_ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = $clog2(N);

  state_t state, state_next;

  logic [WIDTH-1:0]       a_sh, b_sh;
  logic [2:0]             op_q;
  logic                   carry;
  logic [CW-1:0]          cnt;
  // Holds the digits produced so far, newest at the top; only the upper
  // WIDTH-DIGIT bits need storage since the final digit comes straight
  // from the slice on the completing edge.
  logic [WIDTH-DIGIT-1:0] acc;
  logic [WIDTH-1:0]       acc_next;

  logic [DIGIT-1:0] slice_y;
  logic             slice_co;
  logic             slice_cm;
  logic             accept;
  logic             last;

  alu_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .c_in  (carry),
    .op    (op_q),
    .y     (slice_y),
    .c_out (slice_co),
    .c_msb (slice_cm)
  );

  assign accept    = start && (state != RUN);
  assign last      = (state == RUN) && (cnt == CW'(N - 1));
  assign acc_next  = {slice_y, acc};
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(N - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit shifting and result load on the completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
      c_out  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      op_q  <= op;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_next[WIDTH-1:DIGIT];
      carry <= slice_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        result <= acc_next;
        c_out  <= slice_co;
      end
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  // Status flags load alongside result; ovf uses the carry into the MSB
  // seen by the slice during the final RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (last) begin
      zero <= (acc_next == '0);
      ovf  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? (slice_cm ^ slice_co) : 1'b0;
    end
  end
`else
  logic unused_cm;
  assign unused_cm = slice_cm;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed vectors for an 8-bit/1-bit-digit and a
// 16-bit/4-bit-digit serial_alu; expected values hand-computed.
module tb_serial_alu;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start8, cin8, busy8, done8, co8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic [1:0]  state8;
  logic        start16, cin16, busy16, done16, co16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, res16;
  logic [1:0]  state16;
`ifdef SERIAL_ALU_FLAGS_EN
  logic zero8, ovf8, zero16, ovf16;
`endif

  serial_alu #(.WIDTH(8), .DIGIT(1)) u_alu8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .c_in(cin8), .busy(busy8), .done(done8), .result(res8), .c_out(co8),
`ifdef SERIAL_ALU_FLAGS_EN
    .zero(zero8), .ovf(ovf8),
`endif
    .state_dbg(state8)
  );

  serial_alu #(.WIDTH(16), .DIGIT(4)) u_alu16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .c_in(cin16), .busy(busy16), .done(done16), .result(res16), .c_out(co16),
`ifdef SERIAL_ALU_FLAGS_EN
    .zero(zero16), .ovf(ovf16),
`endif
    .state_dbg(state16)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          sel;   // 0: 8-bit DUT, 1: 16-bit DUT
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] res;
    logic        co, z, v;
  } vec_t;

  function automatic vec_t mk(input int sel, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic ci, input logic [15:0] res,
                              input logic co, input logic z, input logic v);
    vec_t t;
    t.sel = sel; t.op = op; t.a = a; t.b = b; t.ci = ci;
    t.res = res; t.co = co; t.z = z; t.v = v;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one request, returns the number of rising edges from the
  // accepting edge (counted as 1) up to the edge after which done is seen.
  task automatic run_op(input int sel, input logic [2:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic ci, output int lat);
    @(negedge clk);
    if (sel == 0) begin
      op8 = o; a8 = va[7:0]; b8 = vb[7:0]; cin8 = ci; start8 = 1'b1;
    end else begin
      op16 = o; a16 = va; b16 = vb; cin16 = ci; start16 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    lat = 1;
    while (lat < 40 && !((sel == 0) ? done8 : done16)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int lat;
    run_op(v.sel, v.op, v.a, v.b, v.ci, lat);
    check_val({tag, "_lat"}, lat, (v.sel == 0) ? 9 : 5);
    if (v.sel == 0) begin
      check_val({tag, "_res"}, {24'h0, res8}, {16'h0, v.res});
      check_val({tag, "_cout"}, co8, v.co);
`ifdef SERIAL_ALU_FLAGS_EN
      check_val({tag, "_zero"}, zero8, v.z);
      check_val({tag, "_ovf"}, ovf8, v.v);
`endif
    end else begin
      check_val({tag, "_res"}, {16'h0, res16}, {16'h0, v.res});
      check_val({tag, "_cout"}, co16, v.co);
`ifdef SERIAL_ALU_FLAGS_EN
      check_val({tag, "_zero"}, zero16, v.z);
      check_val({tag, "_ovf"}, ovf16, v.v);
`endif
    end
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, (v.sel == 0) ? done8 : done16, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[$];
  int   lat;
  logic saw;

  initial begin
    reset = 1'b1;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start16 = 0; op16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy8", busy8, 0);
    check_val("rst_done8", done8, 0);
    check_val("rst_res8", res8, 0);
    check_val("rst_cout8", co8, 0);
    check_val("rst_state8", state8, 0);
    check_val("rst_res16", res16, 0);
`ifdef SERIAL_ALU_FLAGS_EN
    check_val("rst_zero8", zero8, 0);
    check_val("rst_ovf8", ovf8, 0);
`endif
    @(negedge clk) reset = 1'b0;

    //              sel op      a        b        ci  res      co z  v
    vecs.push_back(mk(0, OP_ADD, 16'h7F, 16'h01, 0, 16'h80, 0, 0, 1));
    vecs.push_back(mk(0, OP_SUB, 16'h05, 16'h07, 1, 16'hFE, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB, 16'h07, 16'h07, 1, 16'h00, 1, 1, 0));
    vecs.push_back(mk(0, OP_NOT, 16'hA5, 16'h00, 0, 16'h5A, 0, 0, 0));
    vecs.push_back(mk(0, OP_AND, 16'hF0, 16'h3C, 0, 16'h30, 0, 0, 0));
    vecs.push_back(mk(0, OP_OR,  16'hF0, 16'h3C, 0, 16'hFC, 0, 0, 0));
    vecs.push_back(mk(0, OP_MOV, 16'h81, 16'h55, 0, 16'h81, 0, 0, 0));
    vecs.push_back(mk(0, 3'b110, 16'hFF, 16'hFF, 1, 16'h00, 0, 1, 0));
    vecs.push_back(mk(0, 3'b111, 16'h12, 16'h34, 1, 16'h00, 0, 1, 0));
    vecs.push_back(mk(0, OP_ADD, 16'hFF, 16'h01, 0, 16'h00, 1, 1, 0));
    vecs.push_back(mk(0, OP_ADD, 16'h80, 16'h80, 0, 16'h00, 1, 1, 1));
    vecs.push_back(mk(0, OP_ADD, 16'h00, 16'h00, 1, 16'h01, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB, 16'h05, 16'h03, 0, 16'h01, 1, 0, 0));
    vecs.push_back(mk(0, OP_ADD, 16'h0D, 16'h00, 0, 16'h0D, 0, 0, 0));
    vecs.push_back(mk(1, OP_ADD, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 1, 0));
    vecs.push_back(mk(1, OP_ADD, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 0, 1));
    vecs.push_back(mk(1, OP_SUB, 16'h1234, 16'h0234, 1, 16'h1000, 1, 0, 0));
    vecs.push_back(mk(1, OP_AND, 16'hA5A5, 16'h0FF0, 0, 16'h05A0, 0, 0, 0));

    foreach (vecs[i]) do_vec(vecs[i], $sformatf("v%0d", i));

    // start pulsed at E2 with other operands is dropped
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'h12; b8 = 8'h34; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;          // E0
    @(posedge clk); #1;                          // E1
    a8 = 8'hAA; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;          // E2
    lat = 3;
    while (lat < 40 && !done8) begin @(posedge clk); #1; lat++; end
    check_val("ign_lat", lat, 9);
    check_val("ign_res", res8, 8'h46);
    @(posedge clk); #1;
    check_val("ign_busy_after", busy8, 0);
    check_val("ign_done_after", done8, 0);

    // start held through DONE: second op accepted back-to-back
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'h01; b8 = 8'h02; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1;                          // E0, start kept high
    a8 = 8'h10; b8 = 8'h20;
    lat = 1;
    while (lat < 40 && !done8) begin @(posedge clk); #1; lat++; end
    check_val("b2b_lat1", lat, 9);
    check_val("b2b_res1", res8, 8'h03);
    @(posedge clk); #1; start8 = 1'b0;          // E9 accepts second op
    check_val("b2b_busy", busy8, 1);
    lat = 1;
    while (lat < 40 && !done8) begin @(posedge clk); #1; lat++; end
    check_val("b2b_lat2", lat, 9);
    check_val("b2b_res2", res8, 8'h30);
    @(posedge clk); #1;

    // asynchronous reset in the middle of an ADD
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'h0F; b8 = 8'h01; cin8 = 0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;          // E0
    repeat (4) @(posedge clk);                   // E4
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_busy", busy8, 0);
    check_val("mid_rst_done", done8, 0);
    check_val("mid_rst_res", res8, 0);
    check_val("mid_rst_state", state8, 0);
    @(negedge clk) reset = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw = 1'b1;
    end
    check_val("mid_rst_no_done", saw, 0);
    do_vec(mk(0, OP_ADD, 16'h0F, 16'h01, 0, 16'h10, 0, 0, 0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Parametrised multi-cycle ALU that processes WIDTH-bit operands DIGIT bits per clock, LSB first, through a reusable DIGIT-bit slice. It runs the team's six-operation set (MOV, NOT, ADD, SUB, OR, AND) on full-width words and uses a start/busy/done handshake. It is the width-scalable replacement for the one-bit combinational slice. It sits between the register file and the writeback path in the lab datapath.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of DIGIT, ≥ 2
- DIGIT, 1, bits processed per RUN cycle; N = WIDTH/DIGIT cycles per operation
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only when busy is low
- op  in  3  opcode: 000 MOV a, 001 NOT a, 010 ADD, 011 SUB, 100 OR, 101 AND, 110/111 reserved
- a, b  in  WIDTH  operands; captured on the accepting edge
- c_in  in  1  carry-in for ADD and SUB; captured on the accepting edge
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when result and c_out update
- result  out  WIDTH  registered result; held until the next done
- c_out  out  1  final carry for ADD and SUB; 0 for all other ops

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start=1: latch a, b, op and c_in; cnt=0; carry=c_in; go to RUN. DONE with start=0 goes to IDLE.
- Each RUN cycle: the slice combines a[DIGIT-1:0] and b[DIGIT-1:0] of the shifting operand registers with carry. The slice output shifts into the MSB end of the accumulator. a and b shift right by DIGIT. carry takes the slice carry-out. cnt increments.
- When cnt==N-1 in RUN: next state is DONE. On the same edge, result and c_out load from the completed accumulator and carry.
- ADD: a + b + c_in. SUB: a + ~b + c_in; the caller drives c_in=1 for a two's-complement subtract. c_out is the carry out of the MSB, with no inversion for SUB.
- MOV, NOT, OR, AND: bitwise; c_out=0. Reserved opcodes: result=0, c_out=0.
- start while busy=1 is ignored. No queueing.
- Reset at any time, including mid-RUN: state IDLE; busy, done, result, c_out and flags all 0; the operation is lost.

## Timing
- Accepting edge E0. RUN covers edges E1..EN. Outputs load at EN. done=1 in the cycle after EN.
- Latency from start to done: N+1 cycles (WIDTH=16, DIGIT=1 gives 17).
- Back-to-back: a start held during DONE is accepted at E(N+1). Throughput is one operation per N+1 cycles.
- result and c_out stay stable from EN until the next completing edge. Partial sums are never visible.
- Reset values: busy=0, done=0, result=0, c_out=0, zero=0, ovf=0.

## Configuration
- SERIAL_ALU_FLAGS_EN defined:
  - Adds two 1-bit registered outputs, loaded with result at EN.
  - zero: result==0.
  - ovf: signed overflow for ADD/SUB, i.e. carry into the MSB XOR carry out. ovf=0 for other ops.
  - The carry into the MSB is captured in the final RUN cycle.
- SERIAL_ALU_FLAGS_EN undefined: the zero and ovf ports and their logic are absent. All other behaviour is identical.

## Structure
- Package alu_pkg holds:
  - the opcode localparams OP_MOV through OP_AND;
  - the state enum (IDLE, RUN, DONE);
  - a function that returns N from WIDTH and DIGIT.
- Sub-module alu_slice (parameter DIGIT) is purely combinational: inputs a, b, carry-in and op; outputs DIGIT-bit result, carry-out, and carry into its top bit (used for ovf).
- The top level holds only the FSM, the counter and the shift registers.

## Test plan
- WIDTH=8, DIGIT=1, ADD a=0x7F, b=0x01, c_in=0 -> done exactly 9 cycles after E0; result=0x80, c_out=0, ovf=1, zero=0.
- SUB a=0x05, b=0x07, c_in=1 -> result=0xFE, c_out=0. SUB a=0x07, b=0x07, c_in=1 -> result=0x00, c_out=1, zero=1.
- NOT a=0xA5 -> 0x5A. AND 0xF0,0x3C -> 0x30. OR 0xF0,0x3C -> 0xFC. MOV 0x81 -> 0x81. op=110 -> 0x00. c_out=0 in all these cases.
- Pulse start again at E2 with different operands -> ignored; the first result is unchanged. A start held through DONE -> the second op is accepted and its done arrives 9 cycles later.
- Assert reset at E4 of an ADD -> busy, done and result are 0 immediately (asynchronous). No done follows. A new ADD then completes normally.
- WIDTH=16, DIGIT=4, ADD 0xFFFF + 0x0001 -> done 5 cycles after E0; result=0x0000, c_out=1, zero=1.
